// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_arbiter
//  Description : Shares one CORDIC pipe between NUM_REQ angle requesters.
//                Round-robin grant, one 1-cycle pipe load per grant, tag line
//                that follows each issue through the pipe so the returning
//                x/y result is routed back to the requester that issued it.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                req_valid/req_angle   - requester side, packed per requester
//                req_ready             - one-hot grant (combinational)
//                pipe_load/pipe_angle  - to pipe data_loaded / angle
//                pipe_x/pipe_y/pipe_done - from pipe results / data_computed
//                rsp_valid/rsp_x/rsp_y - one-hot result strobe and data
//                busy                  - any issue in flight or FSM not idle
//                err_orphan/err_missing - sticky tag/result mismatch flags
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_arbiter #(
    parameter int NUM_WIDTH    = 24,
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LATENCY = 22,
    parameter int ISSUE_GAP    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*NUM_WIDTH-1:0] req_angle,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         pipe_load,
    output logic [NUM_WIDTH-1:0]         pipe_angle,
    input  logic [NUM_WIDTH-1:0]         pipe_x,
    input  logic [NUM_WIDTH-1:0]         pipe_y,
    input  logic                         pipe_done,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [NUM_WIDTH-1:0]         rsp_x,
    output logic [NUM_WIDTH-1:0]         rsp_y,
    output logic                         busy,
    output logic                         err_orphan,
    output logic                         err_missing
);

    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_GAP_W = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [c_ID_W-1:0]       r_rr_ptr;
    logic [c_ID_W-1:0]       r_grant_id;
    logic [c_GAP_W-1:0]      r_gap_cnt;
    logic [NUM_WIDTH-1:0]    r_pipe_angle;

    logic [PIPE_LATENCY-1:0] r_tag_vld;
    logic [c_ID_W-1:0]       r_tag_id [PIPE_LATENCY];

    logic [NUM_REQ-1:0]      r_rsp_valid;
    logic [NUM_WIDTH-1:0]    r_rsp_x;
    logic [NUM_WIDTH-1:0]    r_rsp_y;
    logic                    r_err_orphan;
    logic                    r_err_missing;

    logic                    w_found;
    logic [c_ID_W-1:0]       w_grant_id;
    logic [c_ID_W-1:0]       w_idx;
    logic                    w_grant;
    logic                    w_tail_vld;
    logic [c_ID_W-1:0]       w_tail_id;

    // (base + off) mod NUM_REQ without a general divider; off < NUM_REQ.
    function automatic logic [c_ID_W-1:0] f_wrap(input logic [c_ID_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return c_ID_W'(s);
    endfunction

    // ------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after the pointer,
    // wrapping around.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = f_wrap(r_rr_ptr, k);
            if (!w_found && req_valid[w_idx]) begin
                w_found    = 1'b1;
                w_grant_id = w_idx;
            end
        end
    end

    // Gating with rst keeps a requester from seeing a handshake in a cycle
    // whose state update is about to be discarded.
    assign w_grant = (r_state == ST_IDLE) && (r_gap_cnt == '0) && w_found && !rst;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        pipe_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    req_ready   = NUM_REQ'(1) << w_grant_id;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pipe_load   = 1'b1;
                // With ISSUE_GAP == 1 the gap phase is empty.
                w_state_nxt = (ISSUE_GAP > 1) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (r_gap_cnt <= c_GAP_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Issue datapath: angle capture on the handshake, pointer advance on
    // the issue cycle, gap countdown.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_angle <= '0;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
            r_gap_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_pipe_angle <= req_angle[w_grant_id*NUM_WIDTH +: NUM_WIDTH];
                r_grant_id   <= w_grant_id;
            end
            if (r_state == ST_ISSUE) begin
                r_rr_ptr  <= f_wrap(r_grant_id, 1);
                r_gap_cnt <= c_GAP_W'(ISSUE_GAP - 1);
            end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag line: an entry enters at the end of the issue cycle and sits in
    // the last stage exactly in the cycle the pipe should raise pipe_done.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_vld <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_vld <= {r_tag_vld[PIPE_LATENCY-2:0], (r_state == ST_ISSUE)};
            r_tag_id[0] <= r_grant_id;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    assign w_tail_vld = r_tag_vld[PIPE_LATENCY-1];
    assign w_tail_id  = r_tag_id[PIPE_LATENCY-1];

    // ------------------------------------------------------------------------
    // Response routing and sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid   <= '0;
            r_rsp_x       <= '0;
            r_rsp_y       <= '0;
            r_err_orphan  <= 1'b0;
            r_err_missing <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (w_tail_vld && pipe_done) begin
                r_rsp_valid <= NUM_REQ'(1) << w_tail_id;
                r_rsp_x     <= pipe_x;
                r_rsp_y     <= pipe_y;
            end
            if (w_tail_vld && !pipe_done) begin
                r_err_missing <= 1'b1;
            end
            if (!w_tail_vld && pipe_done) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign pipe_angle  = r_pipe_angle;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_x       = r_rsp_x;
    assign rsp_y       = r_rsp_y;
    assign err_orphan  = r_err_orphan;
    assign err_missing = r_err_missing;
    assign busy        = (|r_tag_vld) || (r_state != ST_IDLE);

endmodule
`default_nettype wire
